mult_arbiter: RTL and testbench

- Round-robin scheduler that shares one `mult` multiplier instance (width W) between NUM_REQ independent requesters.
- Accepts one operand pair at a time and sequences the multiplier's input_available / result_rdy / result_taken handshake.
- Returns the product to the granting requester through a per-requester response handshake.
- Sits between the client blocks and the single `mult` instance; `mult` and this block share clk and reset.

---
 rtl/mult_arbiter.sv | 138 +++++++++++++
 tb/tb_mult_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin front end that time-shares a single `mult` instance between
//   NUM_REQ requesters. One operand pair is in flight at a time; the block
//   sequences the mult input/result handshake and hands the product back to
//   the requester that was granted.
//
// Handshakes:
//   Request  : requester i holds req_valid[i] with its operands until it sees
//              the one-cycle req_ready[i] pulse; the operands are latched on
//              the edge that raises req_ready.
//   Response : resp_valid[owner] stays high with resp_data held until the
//              owner asserts resp_taken[owner]; the edge that samples it
//              completes the transaction.
//   Mult side: mult_input_available is a one-cycle pulse with operands stable;
//              mult_result_taken mirrors mult_result_rdy, but only in WAIT.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_operands_A/B   : per-requester request side
//   resp_valid/resp_data/resp_taken         : per-requester response side
//   mult_*                                  : connection to the shared mult
//   busy, owner                             : status
//   state_dbg                               : FSM state (0 IDLE, 1 ISSUE,
//                                             2 WAIT, 3 RESP)
module mult_arbiter #(
  parameter int W       = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*W-1:0]   req_operands_A,
  input  logic [NUM_REQ*W-1:0]   req_operands_B,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [W-1:0]           resp_data,
  input  logic [NUM_REQ-1:0]     resp_taken,
  output logic                   mult_input_available,
  output logic [W-1:0]           mult_operands_bits_A,
  output logic [W-1:0]           mult_operands_bits_B,
  input  logic [W-1:0]           mult_result_bits_data,
  input  logic                   mult_result_rdy,
  output logic                   mult_result_taken,
  output logic                   busy,
  output logic [ID_W-1:0]        owner,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic [ID_W:0]   cand_w;
  logic [ID_W-1:0] cand;

  // Search upward from the round-robin pointer, wrapping modulo NUM_REQ.
  // The extra bit in cand_w keeps ptr+i from overflowing before the wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_w     = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_w = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand_w >= (ID_W+1)'(NUM_REQ)) cand_w = cand_w - (ID_W+1)'(NUM_REQ);
      cand = cand_w[ID_W-1:0];
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Result acceptance is only meaningful while a product is being awaited;
  // a stray result_rdy in any other state must not be consumed.
  assign mult_result_taken = (state == S_WAIT) && mult_result_rdy;
  assign state_dbg         = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= S_IDLE;
      rr_ptr               <= '0;
      owner                <= '0;
      req_ready            <= '0;
      resp_valid           <= '0;
      resp_data            <= '0;
      mult_input_available <= 1'b0;
      mult_operands_bits_A <= '0;
      mult_operands_bits_B <= '0;
      busy                 <= 1'b0;
    end else begin
      // Both pulses default low so each is high for exactly one cycle.
      req_ready            <= '0;
      mult_input_available <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            mult_operands_bits_A <= req_operands_A[pick_idx*W +: W];
            mult_operands_bits_B <= req_operands_B[pick_idx*W +: W];
            owner                <= pick_idx;
            req_ready            <= NUM_REQ'(1) << pick_idx;
            busy                 <= 1'b1;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mult_input_available <= 1'b1;
          state                <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_result_rdy) begin
            resp_data  <= mult_result_bits_data;
            resp_valid <= NUM_REQ'(1) << owner;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_taken[owner]) begin
            resp_valid <= '0;
            rr_ptr     <= (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter. Contains a small behavioural mult that accepts
// operands on input_available, raises result_rdy a few cycles later and
// drops it when result_taken is sampled. Inputs are driven and outputs are
// sampled on the falling edge.
module tb_mult_arbiter;

  localparam int W       = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a = '0;
  logic [NUM_REQ*W-1:0] req_b = '0;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [W-1:0]         resp_data;
  logic [NUM_REQ-1:0]   resp_taken = '0;
  logic                 mult_input_available;
  logic [W-1:0]         mult_operands_bits_A;
  logic [W-1:0]         mult_operands_bits_B;
  logic [W-1:0]         mult_result_bits_data;
  logic                 mult_result_rdy;
  logic                 mult_result_taken;
  logic                 busy;
  logic [ID_W-1:0]      owner;
  logic [1:0]           state_dbg;
  logic                 stray_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int ia_cnt = 0;
  int rr_cnt = 0;
  int oh_err = 0;

  mult_arbiter #(.W(W), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_operands_A       (req_a),
    .req_operands_B       (req_b),
    .resp_valid           (resp_valid),
    .resp_data            (resp_data),
    .resp_taken           (resp_taken),
    .mult_input_available (mult_input_available),
    .mult_operands_bits_A (mult_operands_bits_A),
    .mult_operands_bits_B (mult_operands_bits_B),
    .mult_result_bits_data(mult_result_bits_data),
    .mult_result_rdy      (mult_result_rdy),
    .mult_result_taken    (mult_result_taken),
    .busy                 (busy),
    .owner                (owner),
    .state_dbg            (state_dbg)
  );

  // ---------------- behavioural mult ----------------
  logic         m_busy;
  logic         m_rdy;
  logic [W-1:0] m_prod;
  int           m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_rdy  <= 1'b0;
      m_prod <= '0;
      m_cnt  <= 0;
    end else if (!m_busy && !m_rdy && mult_input_available) begin
      m_busy <= 1'b1;
      m_prod <= mult_operands_bits_A * mult_operands_bits_B;
      m_cnt  <= 3;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_rdy  <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_rdy && mult_result_taken) begin
      m_rdy <= 1'b0;
    end
  end

  assign mult_result_rdy       = m_rdy | stray_rdy;
  assign mult_result_bits_data = m_prod;

  // Pulse counters and one-hot watch on req_ready.
  always @(negedge clk) begin
    if (mult_input_available) ia_cnt++;
    if (req_ready != '0) rr_cnt++;
    if ($countones(req_ready) > 1) oh_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = '0;
    resp_taken = '0;
    stray_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  task automatic wait_ready(output logic [NUM_REQ-1:0] rr, output bit ok);
    ok = 1'b0;
    rr = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        rr = req_ready;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp(output logic [NUM_REQ-1:0] rv, output bit ok);
    ok = 1'b0;
    rv = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        rv = resp_valid;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take_resp(input int idx);
    resp_taken      = '0;
    resp_taken[idx] = 1'b1;
    @(negedge clk);
    resp_taken = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = 4'hF;
    reset     = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mult_input_available, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rr=%b rv=%b ia=%b busy=%b, expected all 0",
               req_ready, resp_valid, mult_input_available, busy);
    end
    checks++;
    if ({resp_data, mult_operands_bits_A, mult_operands_bits_B} !== 48'b0) begin
      errors++;
      $display("FAIL reset_data: got data=%0d A=%0d B=%0d, expected 0",
               resp_data, mult_operands_bits_A, mult_operands_bits_B);
    end
    checks++;
    if (owner !== 2'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got owner=%0d state=%0d, expected 0/0", owner, state_dbg);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] v;
    bit ok;
    do_reset();
    #1;
    ia_cnt = 0;
    rr_cnt = 0;
    set_ops(0, 16'd7, 16'd6);
    req_valid = 4'b0001;
    wait_ready(v, ok);
    checks++;
    if (!ok || v !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got req_ready=%b ok=%0d, expected 0001", v, ok);
    end
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || owner !== 2'd0 || mult_input_available !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: got busy=%b owner=%0d ia=%b, expected 1/0/0",
               busy, owner, mult_input_available);
    end
    @(negedge clk);
    checks++;
    if (mult_input_available !== 1'b1 || mult_operands_bits_A !== 16'd7 ||
        mult_operands_bits_B !== 16'd6) begin
      errors++;
      $display("FAIL single_ia: got ia=%b A=%0d B=%0d, expected 1/7/6",
               mult_input_available, mult_operands_bits_A, mult_operands_bits_B);
    end
    @(negedge clk);
    checks++;
    if (mult_input_available !== 1'b0) begin
      errors++;
      $display("FAIL single_ia_pulse: got ia=%b, expected 0", mult_input_available);
    end
    wait_resp(v, ok);
    checks++;
    if (!ok || v !== 4'b0001 || resp_data !== 16'd42) begin
      errors++;
      $display("FAIL single_resp: got rv=%b data=%0d, expected 0001/42", v, resp_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || busy !== 1'b1 || resp_data !== 16'd42) begin
      errors++;
      $display("FAIL single_hold: got rv=%b busy=%b data=%0d, expected 0001/1/42",
               resp_valid, busy, resp_data);
    end
    take_resp(0);
    checks++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got rv=%b busy=%b, expected 0000/0", resp_valid, busy);
    end
    #1;
    checks++;
    if (ia_cnt !== 1 || rr_cnt !== 1) begin
      errors++;
      $display("FAIL single_pulses: got ia=%0d rr=%0d, expected 1/1", ia_cnt, rr_cnt);
    end
  endtask

  task automatic test_one_req(input string name, input int idx, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp);
    logic [NUM_REQ-1:0] v;
    logic [NUM_REQ-1:0] exp_bit;
    bit ok;
    exp_bit = '0;
    exp_bit[idx] = 1'b1;
    set_ops(idx, a, b);
    req_valid = exp_bit;
    wait_ready(v, ok);
    req_valid = '0;
    checks++;
    if (!ok || v !== exp_bit || owner !== ID_W'(idx)) begin
      errors++;
      $display("FAIL %s_grant: got rr=%b owner=%0d, expected %b/%0d", name, v, owner, exp_bit, idx);
    end
    wait_resp(v, ok);
    checks++;
    if (!ok || v !== exp_bit || resp_data !== exp) begin
      errors++;
      $display("FAIL %s_resp: got rv=%b data=%0d, expected %b/%0d", name, v, resp_data, exp_bit, exp);
    end
    take_resp(idx);
  endtask

  task automatic test_zero_and_overflow();
    test_one_req("zero", 2, 16'd1234, 16'd0, 16'd0);
    test_one_req("overflow", 1, 16'd300, 16'd300, 16'd24464);
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] v;
    bit ok;
    do_reset();
    #1;
    oh_err = 0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, W'(i + 1), 16'd10);
    req_valid = 4'hF;
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_ready(v, ok);
      checks++;
      if (!ok || v !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL contention_grant%0d: got rr=%b, expected %b", k, v, 4'b0001 << k);
      end
      req_valid = req_valid & ~v;
      wait_resp(v, ok);
      checks++;
      if (!ok || v !== (4'b0001 << k) || resp_data !== W'((k + 1) * 10)) begin
        errors++;
        $display("FAIL contention_resp%0d: got rv=%b data=%0d, expected %b/%0d",
                 k, v, resp_data, 4'b0001 << k, (k + 1) * 10);
      end
      take_resp(k);
    end
    req_valid = '0;
    #1;
    checks++;
    if (oh_err !== 0) begin
      errors++;
      $display("FAIL contention_onehot: got %0d multi-hot cycles, expected 0", oh_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] v;
    bit ok;
    int ia0;
    int rr0;
    int hold_bad;
    // Pointer is at 0 after the contention round.
    set_ops(1, 16'd2, 16'd3);
    set_ops(0, 16'd9, 16'd9);
    set_ops(2, 16'd5, 16'd5);
    req_valid = 4'b0010;
    wait_ready(v, ok);
    req_valid = '0;
    checks++;
    if (!ok || v !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant1: got rr=%b, expected 0010", v);
    end
    wait_resp(v, ok);
    checks++;
    if (!ok || v !== 4'b0010 || resp_data !== 16'd6) begin
      errors++;
      $display("FAIL bp_resp1: got rv=%b data=%0d, expected 0010/6", v, resp_data);
    end
    // Backpressure with competing requests, a non-owner take and a stray rdy.
    req_valid  = 4'b0101;
    resp_taken = 4'b0001;
    stray_rdy  = 1'b1;
    #1;
    ia0 = ia_cnt;
    rr0 = rr_cnt;
    hold_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid !== 4'b0010 || mult_result_taken !== 1'b0 || resp_data !== 16'd6)
        hold_bad++;
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles (rv=%b taken=%b), expected 0",
               hold_bad, resp_valid, mult_result_taken);
    end
    stray_rdy  = 1'b0;
    resp_taken = '0;
    #1;
    checks++;
    if (ia_cnt !== ia0 || rr_cnt !== rr0) begin
      errors++;
      $display("FAIL bp_quiet: got ia=%0d rr=%0d extra pulses, expected 0/0",
               ia_cnt - ia0, rr_cnt - rr0);
    end
    take_resp(1);
    wait_ready(v, ok);
    req_valid = req_valid & ~v;
    checks++;
    if (!ok || v !== 4'b0100) begin
      errors++;
      $display("FAIL bp_order2: got rr=%b, expected 0100", v);
    end
    wait_resp(v, ok);
    checks++;
    if (!ok || v !== 4'b0100 || resp_data !== 16'd25) begin
      errors++;
      $display("FAIL bp_resp2: got rv=%b data=%0d, expected 0100/25", v, resp_data);
    end
    take_resp(2);
    wait_ready(v, ok);
    req_valid = req_valid & ~v;
    checks++;
    if (!ok || v !== 4'b0001) begin
      errors++;
      $display("FAIL bp_order0: got rr=%b, expected 0001", v);
    end
    wait_resp(v, ok);
    checks++;
    if (!ok || v !== 4'b0001 || resp_data !== 16'd81) begin
      errors++;
      $display("FAIL bp_resp0: got rv=%b data=%0d, expected 0001/81", v, resp_data);
    end
    take_resp(0);
  endtask

  task automatic test_reset_mid_wait();
    logic [NUM_REQ-1:0] v;
    bit ok;
    int stale;
    set_ops(0, 16'd5, 16'd9);
    req_valid = 4'b0001;
    wait_ready(v, ok);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midwait_state: got state=%0d busy=%b, expected 2/1", state_dbg, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mult_input_available, busy, owner, state_dbg} !== 14'b0 ||
        {resp_data, mult_operands_bits_A, mult_operands_bits_B} !== 48'b0) begin
      errors++;
      $display("FAIL midwait_reset: got rv=%b busy=%b state=%0d A=%0d data=%0d, expected 0",
               resp_valid, busy, state_dbg, mult_operands_bits_A, resp_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid !== '0 || busy !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midwait_noresp: got %0d cycles with activity, expected 0", stale);
    end
    test_one_req("after_reset", 0, 16'd3, 16'd4, 16'd12);
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_and_overflow();
    test_contention();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
